// File: rtl/pipe_out_arbiter.sv
// rtl/pipe_out_arbiter.sv - round-robin block arbiter feeding four sources into one host pipe
// A source is granted a whole block of BLOCK_WORDS words; the host drains it before re-arbitration.
module pipe_out_arbiter #(
  parameter int WIDTH       = 32,
  parameter int BLOCK_WORDS = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pipe_out_read,
  output logic [WIDTH-1:0]     pipe_out_data,
  output logic                 pipe_out_ready,
  input  logic [3:0]           src_ready,
  input  logic [4*WIDTH-1:0]   src_data,
  output logic [3:0]           src_read,
  input  logic [3:0]           src_enable,
  output logic [1:0]           grant_id,
  output logic                 busy,
  output logic [15:0]          block_count,
  output logic                 read_err
);

  localparam logic [15:0] LAST_WORD = 16'(BLOCK_WORDS - 1);

  typedef enum logic [1:0] {IDLE, GRANT, XFER} state_e;

  state_e           state_q, state_d;
  logic [1:0]       grant_q, grant_d;
  logic [1:0]       last_q, last_d;
  logic [15:0]      word_cnt_q, word_cnt_d;
  logic [15:0]      block_cnt_q, block_cnt_d;
  logic             read_err_q, read_err_d;
  logic [WIDTH-1:0] hold_q, hold_d;

  logic [3:0]       req;
  logic [1:0]       cand;
  logic [1:0]       pick;
  logic             found;
  logic [WIDTH-1:0] grant_word;

  assign grant_word  = src_data[int'(grant_q)*WIDTH +: WIDTH];
  assign grant_id    = grant_q;
  assign block_count = block_cnt_q;
  assign read_err    = read_err_q;

  // Search starts one past the last completed grant so every requester gets a turn.
  always_comb begin
    req   = src_ready & src_enable;
    cand  = 2'd0;
    pick  = 2'd0;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cand = last_q + 2'(k + 1);
      if (!found && req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    last_d         = last_q;
    word_cnt_d     = word_cnt_q;
    block_cnt_d    = block_cnt_q;
    read_err_d     = read_err_q;
    hold_d         = hold_q;
    src_read       = 4'b0000;
    pipe_out_ready = 1'b0;
    busy           = 1'b0;
    pipe_out_data  = hold_q;

    case (state_q)
      IDLE: begin
        if (pipe_out_read) read_err_d = 1'b1;
        if (found) begin
          grant_d = pick;
          state_d = GRANT;
        end
      end
      GRANT: begin
        busy       = 1'b1;
        word_cnt_d = 16'd0;
        if (pipe_out_read) read_err_d = 1'b1;
        state_d    = XFER;
      end
      XFER: begin
        busy           = 1'b1;
        pipe_out_ready = (word_cnt_q == 16'd0);
        pipe_out_data  = grant_word;
        hold_d         = grant_word;
        if (pipe_out_read) begin
          src_read   = 4'b0001 << grant_q;
          word_cnt_d = word_cnt_q + 16'd1;
          // Block end ignores the source's ready/enable: a granted block always completes.
          if (word_cnt_q == LAST_WORD) begin
            block_cnt_d = block_cnt_q + 16'd1;
            last_d      = grant_q;
            state_d     = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_q     <= 2'd0;
      last_q      <= 2'd3;
      word_cnt_q  <= 16'd0;
      block_cnt_q <= 16'd0;
      read_err_q  <= 1'b0;
      hold_q      <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      word_cnt_q  <= word_cnt_d;
      block_cnt_q <= block_cnt_d;
      read_err_q  <= read_err_d;
      hold_q      <= hold_d;
    end
  end

endmodule

// File: tb/tb_pipe_out_arbiter.sv
// tb/tb_pipe_out_arbiter.sv - scoreboard bench for pipe_out_arbiter
module tb_pipe_out_arbiter;

  localparam int W  = 32;
  localparam int BW = 1024;

  logic           clk = 1'b0;
  logic           reset;
  logic           pipe_out_read;
  logic [W-1:0]   pipe_out_data;
  logic           pipe_out_ready;
  logic [3:0]     src_ready;
  logic [4*W-1:0] src_data;
  logic [3:0]     src_read;
  logic [3:0]     src_enable;
  logic [1:0]     grant_id;
  logic           busy;
  logic [15:0]    block_count;
  logic           read_err;

  pipe_out_arbiter #(.WIDTH(W), .BLOCK_WORDS(BW)) dut (
    .clk(clk), .reset(reset),
    .pipe_out_read(pipe_out_read), .pipe_out_data(pipe_out_data),
    .pipe_out_ready(pipe_out_ready),
    .src_ready(src_ready), .src_data(src_data), .src_read(src_read),
    .src_enable(src_enable), .grant_id(grant_id), .busy(busy),
    .block_count(block_count), .read_err(read_err)
  );

  always #5 clk = ~clk;

  // Each source is a FIFO whose words are {source id, sequence number}.
  logic [23:0] src_cnt [4] = '{default: 24'd0};
  logic [23:0] exp_word [4] = '{default: 24'd0};

  always @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (src_read[i] === 1'b1) src_cnt[i] <= src_cnt[i] + 24'd1;

  for (genvar g = 0; g < 4; g++) begin : g_src
    assign src_data[g*W +: W] = {8'(g), src_cnt[g]};
  end

  typedef struct packed {
    logic [W-1:0] data;
    logic [3:0]   rd;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   blk_exp  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (pipe_out_read === 1'b1) begin
      exp_t e;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_underflow: got read with empty queue at %0t", $time);
      end else begin
        e = sb.pop_front();
        chk("read_data", 64'(pipe_out_data), 64'(e.data));
        chk("read_strobe", 64'(src_read), 64'(e.rd));
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals;
    chk("rst_ready", 64'(pipe_out_ready), 64'd0);
    chk("rst_src_read", 64'(src_read), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_block_count", 64'(block_count), 64'd0);
    chk("rst_read_err", 64'(read_err), 64'd0);
    chk("rst_grant_id", 64'(grant_id), 64'd0);
    chk("rst_data", 64'(pipe_out_data), 64'd0);
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (pipe_out_ready !== 1'b1 && n < 50) begin
      tick;
      n++;
    end
    chk("ready_wait", 64'(pipe_out_ready), 64'd1);
  endtask

  task automatic issue_read(input int s);
    pipe_out_read = 1'b1;
    sb.push_back('{data: {8'(s), exp_word[s]}, rd: 4'b0001 << s});
    exp_word[s] = exp_word[s] + 24'd1;
  endtask

  // Drains one block from source s; gap < 0 skips the gap check; src_ready becomes rdy_new at word chg_at.
  task automatic rd_block(input int s, input int gap, input int chg_at, input logic [3:0] rdy_new);
    int n;
    wait_ready(n);
    if (gap >= 0) chk("gap", 64'(n), 64'(gap));
    chk("grant_id", 64'(grant_id), 64'(s));
    chk("busy_xfer", 64'(busy), 64'd1);
    for (int w = 0; w < BW; w++) begin
      if (w == chg_at) src_ready = rdy_new;
      issue_read(s);
      if (w == 1) chk("ready_low", 64'(pipe_out_ready), 64'd0);
      tick;
    end
    pipe_out_read = 1'b0;
    blk_exp++;
    chk("busy_idle", 64'(busy), 64'd0);
    chk("block_count", 64'(block_count), 64'(16'(blk_exp)));
    chk("data_hold", 64'(pipe_out_data), 64'({8'(s), exp_word[s] - 24'd1}));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1;
    pipe_out_read = 1'b0;
    src_ready = 4'h0;
    src_enable = 4'hF;
    tick;
    chk_reset_vals;
    tick;
    reset = 1'b0;
    tick;

    // Reads with nothing granted
    for (int i = 0; i < 3; i++) begin
      pipe_out_read = 1'b1;
      sb.push_back('{data: '0, rd: 4'b0000});
      tick;
    end
    pipe_out_read = 1'b0;
    chk("err_set", 64'(read_err), 64'd1);
    tick;
    tick;
    chk("err_sticky", 64'(read_err), 64'd1);
    chk("err_no_block", 64'(block_count), 64'd0);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("err_cleared", 64'(read_err), 64'd0);
    tick;

    // Single requester
    src_ready = 4'b0100;
    rd_block(2, -1, 1000, 4'h0);
    tick;
    chk("single_idle", 64'(busy), 64'd0);

    // Fair rotation, all requesting
    reset = 1'b1;
    tick;
    reset = 1'b0;
    blk_exp = 0;
    src_ready = 4'hF;
    for (int b = 0; b < 8; b++)
      rd_block(b % 4, (b == 0) ? -1 : 2, (b == 7) ? 1000 : -1, 4'h0);
    chk("rr_count", 64'(block_count), 64'd8);

    // Masked sources
    src_enable = 4'b1010;
    src_ready = 4'hF;
    rd_block(1, -1, -1, 4'hF);
    rd_block(3, 2, -1, 4'hF);
    rd_block(1, 2, -1, 4'hF);
    rd_block(3, 2, 1000, 4'h0);

    // Granted source drops ready mid-block
    src_enable = 4'hF;
    src_ready = 4'b0010;
    rd_block(1, -1, 100, 4'b0001);
    rd_block(0, 2, 1000, 4'h0);
    for (int i = 0; i < 5; i++) tick;
    chk("no_regrant_busy", 64'(busy), 64'd0);
    chk("no_regrant_id", 64'(grant_id), 64'd0);
    src_ready = 4'b0010;
    rd_block(1, -1, 1000, 4'h0);

    // Reset mid-block
    src_ready = 4'b1000;
    wait_ready(n);
    chk("mid_grant", 64'(grant_id), 64'd3);
    for (int w = 0; w < 500; w++) begin
      issue_read(3);
      tick;
    end
    pipe_out_read = 1'b0;
    reset = 1'b1;
    tick;
    chk_reset_vals;
    reset = 1'b0;
    blk_exp = 0;
    src_ready = 4'b1001;
    rd_block(0, -1, 1000, 4'h0);

    tick;
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
